// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
package alarm_pkg;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} alarm_state_t;

  typedef struct packed {
    logic [3:0] h_tens;
    logic [3:0] h_units;
    logic [3:0] m_tens;
    logic [3:0] m_units;
  } bcd_hhmm_t;

  localparam int SEC_PER_MIN = 60;

endpackage

// File: rtl/alarm_time_cmp.sv
// Alarm time comparator: HH:MM:00 match plus rising-edge trigger.
// match_q resets high so a time already equal to the alarm at reset
// release does not fire.
module alarm_time_cmp
  import alarm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cur_hhmm,
  input  logic [3:0]  cur_s_tens,
  input  logic [3:0]  cur_s_units,
  input  logic [15:0] alm_hhmm,
  input  logic        alarm_en,
  output logic        match,
  output logic        trigger
);

  bcd_hhmm_t cur, alm;
  logic      match_q;

  assign cur = bcd_hhmm_t'(cur_hhmm);
  assign alm = bcd_hhmm_t'(alm_hhmm);

  // Exact HH:MM equality at the top of the minute.
  always_comb begin
    match = (cur == alm) && (cur_s_tens == 4'd0) && (cur_s_units == 4'd0);
  end

  // Remember last cycle's match to detect its rising edge.
  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b1;
    else     match_q <= match;
  end

  assign trigger = match & ~match_q & alarm_en;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: ring / snooze / stop / auto-off state machine driven
// by the 1 Hz sec_tick. Button decisions take precedence over a tick in
// the same cycle; a button that is ignored has no effect at all.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int SNOOZE_MAX     = 3,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [3:0] cur_h_tens,
  input  logic [3:0] cur_h_units,
  input  logic [3:0] cur_m_tens,
  input  logic [3:0] cur_m_units,
  input  logic [3:0] cur_s_tens,
  input  logic [3:0] cur_s_units,
  input  logic [3:0] alm_h_tens,
  input  logic [3:0] alm_h_units,
  input  logic [3:0] alm_m_tens,
  input  logic [3:0] alm_m_units,
  input  logic       alarm_en,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer,
  output logic [1:0] snooze_cnt
);

  localparam int              SNZ_W    = $clog2(SNOOZE_MIN * SEC_PER_MIN + 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * SEC_PER_MIN);
  localparam logic [7:0]      RING_LIM = 8'(RING_TIMEOUT_S);
  localparam logic [1:0]      SNZ_CAP  = 2'(SNOOZE_MAX);

  bcd_hhmm_t        cur_hhmm, alm_hhmm;
  logic             match, trigger;

  alarm_state_t     state, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [7:0]       ring_sec, ring_d;
  logic [SNZ_W-1:0] snz_sec, snz_d;
  logic             buz_q, buz_d;

  assign cur_hhmm = '{h_tens: cur_h_tens, h_units: cur_h_units,
                      m_tens: cur_m_tens, m_units: cur_m_units};
  assign alm_hhmm = '{h_tens: alm_h_tens, h_units: alm_h_units,
                      m_tens: alm_m_tens, m_units: alm_m_units};

  alarm_time_cmp u_cmp (
    .clk        (clk),
    .rst        (rst),
    .cur_hhmm   (cur_hhmm),
    .cur_s_tens (cur_s_tens),
    .cur_s_units(cur_s_units),
    .alm_hhmm   (alm_hhmm),
    .alarm_en   (alarm_en),
    .match      (match),
    .trigger    (trigger)
  );

  // State, counters and buzzer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt_q    <= 2'd0;
      ring_sec <= 8'd0;
      snz_sec  <= '0;
      buz_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt_q    <= cnt_d;
      ring_sec <= ring_d;
      snz_sec  <= snz_d;
      buz_q    <= buz_d;
    end
  end

  // Next state: alarm_en low > stop > snooze > timeout/expiry > tick.
  always_comb begin
    state_d = state;
    cnt_d   = cnt_q;
    ring_d  = ring_sec;
    snz_d   = snz_sec;
    buz_d   = buz_q;
    if (!alarm_en) begin
      state_d = IDLE;
      cnt_d   = 2'd0;
      ring_d  = 8'd0;
      snz_d   = '0;
      buz_d   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_d = RINGING;
            ring_d  = 8'd0;
            buz_d   = 1'b1;
          end
        end
        RINGING: begin
          if (stop_btn) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            buz_d   = 1'b0;
          end else if (snooze_btn && (cnt_q < SNZ_CAP)) begin
            state_d = SNOOZE;
            cnt_d   = cnt_q + 2'd1;
            snz_d   = SNZ_LOAD;
            buz_d   = 1'b0;
          end else if (ring_sec >= RING_LIM) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
            buz_d   = 1'b0;
          end else if (sec_tick) begin
            ring_d = ring_sec + 8'd1;
            buz_d  = ~buz_q;
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
          end else if (snz_sec == '0) begin
            state_d = RINGING;
            ring_d  = 8'd0;
            buz_d   = 1'b1;
          end else if (sec_tick) begin
            snz_d = snz_sec - 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          buz_d   = 1'b0;
        end
      endcase
    end
  end

  assign ringing    = (state == RINGING);
  assign snoozing   = (state == SNOOZE);
  assign buzzer     = buz_q;
  assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: vector table, hand sequences for multi-cycle
// corners, then random stimulus against a behavioural model.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1, sec_tick = 1'b0, alarm_en = 1'b1;
  logic       snooze_btn = 1'b0, stop_btn = 1'b0;
  logic [3:0] cur_h_tens = '0, cur_h_units = '0, cur_m_tens = '0, cur_m_units = '0;
  logic [3:0] cur_s_tens = '0, cur_s_units = '0;
  logic [3:0] alm_h_tens = '0, alm_h_units = '0, alm_m_tens = '0, alm_m_units = '0;
  logic       ringing, snoozing, buzzer;
  logic [1:0] snooze_cnt;
  logic [4:0] got;

  int n_cmp = 0, n_bad = 0;

  // model state: seconds rung / snooze seconds left, as plain integers
  bit m_ring = 0, m_snz = 0, m_prev = 1;
  int m_cnt = 0, m_re = 0, m_left = 0;

  alarm_ctrl dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .cur_h_tens(cur_h_tens), .cur_h_units(cur_h_units),
    .cur_m_tens(cur_m_tens), .cur_m_units(cur_m_units),
    .cur_s_tens(cur_s_tens), .cur_s_units(cur_s_units),
    .alm_h_tens(alm_h_tens), .alm_h_units(alm_h_units),
    .alm_m_tens(alm_m_tens), .alm_m_units(alm_m_units),
    .alarm_en(alarm_en), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer), .snooze_cnt(snooze_cnt)
  );

  always #5 clk = ~clk;
  assign got = {ringing, snoozing, buzzer, snooze_cnt};

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got r/s/b/cnt=%b required %b", nm, got, exp);
    end
  endtask

  task automatic set_time(input logic [23:0] t);
    {cur_h_tens, cur_h_units, cur_m_tens, cur_m_units, cur_s_tens, cur_s_units} = t;
  endtask

  task automatic set_alm(input logic [15:0] a);
    {alm_h_tens, alm_h_units, alm_m_tens, alm_m_units} = a;
  endtask

  function automatic int mins(input logic [3:0] ht, hu, mt, mu);
    return (ht * 10 + hu) * 60 + mt * 10 + mu;
  endfunction

  // Behavioural reference, advanced with the inputs present before the edge.
  task automatic model_step();
    bit m, trig;
    m = (mins(cur_h_tens, cur_h_units, cur_m_tens, cur_m_units) ==
         mins(alm_h_tens, alm_h_units, alm_m_tens, alm_m_units)) &&
        (cur_s_tens * 10 + cur_s_units == 0);
    trig = m && !m_prev && alarm_en;
    if (rst) begin
      m_ring = 0; m_snz = 0; m_cnt = 0; m_re = 0; m_left = 0;
    end else if (!alarm_en) begin
      m_ring = 0; m_snz = 0; m_cnt = 0;
    end else if (m_ring) begin
      if (stop_btn) begin m_ring = 0; m_cnt = 0; end
      else if (snooze_btn && m_cnt < 3) begin
        m_ring = 0; m_snz = 1; m_cnt++; m_left = 5 * 60;
      end
      else if (m_re == 60) begin m_ring = 0; m_cnt = 0; end
      else if (sec_tick) m_re++;
    end else if (m_snz) begin
      if (stop_btn) begin m_snz = 0; m_cnt = 0; end
      else if (m_left == 0) begin m_snz = 0; m_ring = 1; m_re = 0; end
      else if (sec_tick) m_left--;
    end else if (trig) begin
      m_ring = 1; m_re = 0;
    end
    m_prev = rst ? 1'b1 : m;
  endtask

  function automatic logic [4:0] model_out();
    return {m_ring, m_snz, m_ring && (m_re % 2 == 0), 2'(m_cnt)};
  endfunction

  // One clock: update model, take the edge, sample 1 after it, drop pulses.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    sec_tick = 0; snooze_btn = 0; stop_btn = 0;
  endtask

  task automatic go_ring();
    rst = 1; alarm_en = 1; set_alm(16'h0730);
    cyc(); cyc();
    rst = 0; set_time(24'h072959); cyc();
    set_time(24'h073000); cyc();
    chk("ring_start", 5'b10100);
  endtask

  task automatic snooze_round(input int n);
    snooze_btn = 1; cyc();
    chk("snz_enter", {3'b010, 2'(n)});
    for (int k = 1; k <= 300; k++) begin
      sec_tick = 1;
      if (k == 150) snooze_btn = 1;
      cyc(); cyc();
      if (k == 299) chk("snz_hold", {3'b010, 2'(n)});
    end
    chk("snz_wake", {3'b101, 2'(n)});
  endtask

  typedef struct {
    logic        r, en, tk, sz, sp;
    logic [23:0] t;
    logic [4:0]  exp;
  } vec_t;
  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 0, 24'h072959, 5'b00000};
    tbl[1]  = '{0, 1, 0, 0, 0, 24'h072959, 5'b00000};
    tbl[2]  = '{0, 1, 0, 0, 0, 24'h073000, 5'b10100};
    tbl[3]  = '{0, 1, 1, 0, 0, 24'h073000, 5'b10000};
    tbl[4]  = '{0, 1, 1, 0, 0, 24'h073001, 5'b10100};
    tbl[5]  = '{0, 1, 1, 1, 0, 24'h073001, 5'b01001};
    tbl[6]  = '{0, 1, 0, 0, 1, 24'h073001, 5'b00000};
    tbl[7]  = '{0, 1, 0, 0, 0, 24'h073000, 5'b10100};
    tbl[8]  = '{0, 1, 1, 1, 1, 24'h073000, 5'b00000};
    tbl[9]  = '{0, 1, 0, 0, 0, 24'h073000, 5'b00000};
    tbl[10] = '{0, 1, 0, 0, 0, 24'h073100, 5'b00000};
    tbl[11] = '{0, 0, 0, 0, 0, 24'h073000, 5'b00000};
    tbl[12] = '{0, 1, 0, 0, 0, 24'h073000, 5'b00000};

    set_alm(16'h0730);
    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].r; alarm_en = tbl[i].en; sec_tick = tbl[i].tk;
      snooze_btn = tbl[i].sz; stop_btn = tbl[i].sp; set_time(tbl[i].t);
      cyc();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // auto-off after RING_TIMEOUT_S ticks, buzzer toggling each tick
    go_ring();
    for (int k = 1; k <= 60; k++) begin
      sec_tick = 1; cyc();
      chk("tmo_buz", {2'b10, 1'(k % 2 == 0), 2'b00});
      cyc();
      if (k == 60) chk("tmo_off", 5'b00000);
    end

    // three full snoozes, a fourth press ignored, then stop
    go_ring();
    snooze_round(1);
    snooze_round(2);
    snooze_round(3);
    snooze_btn = 1; cyc();
    chk("snz_max", 5'b10111);
    stop_btn = 1; cyc();
    chk("stop_max", 5'b00000);

    // disarm during snooze
    go_ring();
    snooze_btn = 1; cyc();
    chk("snz_1", 5'b01001);
    alarm_en = 0; cyc();
    chk("en_off", 5'b00000);
    alarm_en = 1; cyc();
    chk("en_back", 5'b00000);

    // time equals alarm while in reset: no ring on release
    set_alm(16'h0000); set_time(24'h000000);
    rst = 1; cyc(); cyc(); cyc();
    rst = 0; cyc();
    chk("rst_match0", 5'b00000);
    cyc();
    chk("rst_match1", 5'b00000);

    // reset mid-ring and mid-snooze
    go_ring();
    sec_tick = 1; cyc();
    rst = 1; cyc();
    chk("rst_ring", 5'b00000);
    go_ring();
    snooze_btn = 1; cyc();
    rst = 1; cyc();
    chk("rst_snz", 5'b00000);

    // random traffic against the model
    set_alm(16'h1234); set_time(24'h120000);
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(3))
          0: set_time(24'h123400);
          1: set_time(24'h123401);
          2: set_time(24'h123359);
          default: set_time(24'h120000);
        endcase
      end
      alarm_en   = ($urandom_range(199) != 0);
      sec_tick   = 1'($urandom_range(1));
      snooze_btn = ($urandom_range(299) == 0);
      stop_btn   = ($urandom_range(999) == 0);
      rst        = ($urandom_range(4999) == 0);
      cyc();
      chk("rand", model_out());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
